imem_loader: RTL

Serial boot loader that fills the CPU's 4096 x 32 instruction memory over a UART link, the writer side of the fetch-stage instruction read port. It receives a framed byte stream on `rx`, assembles little-endian 32-bit words, and issues one write per word at incrementing word addresses starting at 0. While a load is in progress it holds the CPU in reset, so a new program runs from PC 0 immediately after the load completes.

---
 rtl/imem_loader_pkg.sv | 8 +
 rtl/imem_loader_uart_rx.sv | 85 ++++++++
 rtl/imem_loader.sv | 124 ++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encodings and framing constants for the serial loader
package imem_loader_pkg;
  typedef enum logic [2:0] {WAIT_HDR, LEN_LO, LEN_HI, DATA, FINISH} ldr_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP, RX_BREAK} rx_state_t;
  localparam logic [7:0] HDR_DEFAULT = 8'hA5;
  localparam int DATA_BITS = 8;
  localparam int FRAME_BITS = 10;
endpackage

// File: rtl/imem_loader_uart_rx.sv
// uart_rx: 8N1 receiver with start-bit validation and framing-error recovery
module uart_rx
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  rx_state_t state, state_n;
  logic [1:0] sync;
  logic prev, rs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] sh, sh_n;
  logic bv_n, fe_n;
  assign rs = sync[1];
  assign byte_data = sh;
  // synchronize rx and hold receiver state
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      prev <= 1'b1;
      state <= RX_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      byte_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      prev <= rs;
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      byte_valid <= bv_n;
      frame_err <= fe_n;
    end
  end
  // bit timing: half-bit start check, then full-bit spaced samples
  always_comb begin
    state_n = state;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    bv_n = 1'b0;
    fe_n = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (prev && !rs) state_n = RX_START;
      end
      RX_START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        state_n = rs ? RX_IDLE : RX_BITS;
      end
      RX_BITS: if (cnt == FULL) begin
        cnt_n = '0;
        sh_n = {rs, sh[7:1]};
        idx_n = idx + 1'b1;
        if (idx == 3'(DATA_BITS - 1)) state_n = RX_STOP;
      end
      RX_STOP: if (cnt == FULL) begin
        cnt_n = '0;
        bv_n = rs;
        fe_n = !rs;
        state_n = rs ? RX_IDLE : RX_BREAK;
      end
      RX_BREAK: begin
        cnt_n = '0;
        if (rs) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: UART boot loader writing little-endian words into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W = 12,
  parameter logic [7:0] HDR_BYTE = HDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam int RW = ADDR_W + 1;
  ldr_state_t state, state_n;
  logic byte_valid, frame_err;
  logic [7:0] byte_data, len_lo, len_lo_n;
  logic [15:0] n_word;
  logic [RW-1:0] rem, rem_n;
  logic [1:0] byte_idx, idx_n;
  logic [ADDR_W-1:0] waddr_n;
  logic [31:0] wdata_n;
  logic we_n, done_n, hold_n, err_n;
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk),
    .rst(rst),
    .rx(rx),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
    .frame_err(frame_err)
  );
  // loader state and registered memory-write outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_HDR;
      len_lo <= '0;
      rem <= '0;
      byte_idx <= '0;
      waddr <= '0;
      wdata <= '0;
      we <= 1'b0;
      done <= 1'b0;
      cpu_hold <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      len_lo <= len_lo_n;
      rem <= rem_n;
      byte_idx <= idx_n;
      waddr <= waddr_n;
      wdata <= wdata_n;
      we <= we_n;
      done <= done_n;
      cpu_hold <= hold_n;
      err <= err_n;
    end
  end
  // frame parsing; a framing error outside WAIT_HDR abandons the load
  always_comb begin
    state_n = state;
    len_lo_n = len_lo;
    rem_n = rem;
    idx_n = byte_idx;
    waddr_n = (we && state == DATA) ? waddr + 1'b1 : waddr;
    wdata_n = wdata;
    we_n = 1'b0;
    done_n = 1'b0;
    hold_n = cpu_hold;
    err_n = err;
    n_word = {byte_data, len_lo};
    if (frame_err) begin
      err_n = 1'b1;
      if (state != WAIT_HDR) begin
        hold_n = 1'b0;
        state_n = WAIT_HDR;
      end
    end else begin
      case (state)
        WAIT_HDR: if (byte_valid && byte_data == HDR_BYTE) begin
          state_n = LEN_LO;
          err_n = 1'b0;
          hold_n = 1'b1;
          waddr_n = '0;
        end
        LEN_LO: if (byte_valid) begin
          len_lo_n = byte_data;
          state_n = LEN_HI;
        end
        LEN_HI: if (byte_valid) begin
          if (n_word == '0 || 32'(n_word) > (32'd1 << ADDR_W)) begin
            err_n = 1'b1;
            hold_n = 1'b0;
            state_n = WAIT_HDR;
          end else begin
            rem_n = RW'(n_word);
            waddr_n = '0;
            idx_n = '0;
            state_n = DATA;
          end
        end
        DATA: if (byte_valid) begin
          wdata_n[{byte_idx, 3'b000} +: 8] = byte_data;
          idx_n = byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            we_n = 1'b1;
            rem_n = rem - 1'b1;
            if (rem == RW'(1)) state_n = FINISH;
          end
        end
        FINISH: begin
          done_n = 1'b1;
          hold_n = 1'b0;
          state_n = WAIT_HDR;
        end
        default: state_n = WAIT_HDR;
      endcase
    end
  end
endmodule
